// File: rtl/dma_controller.sv
// Single-channel word-copy DMA engine with a 4-register CPU port.
// Moves LEN words from SRC to DST through a read / capture / write cycle,
// re-arbitrating for the bus between words when the grant is withdrawn.
module dma_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_cs,
  input  logic [1:0]  cpu_addr,
  input  logic        cpu_w,
  input  logic        cpu_r,
  input  logic [15:0] cpu_data_in,
  output logic [15:0] cpu_data_out,
  output logic        bus_req,
  input  logic        bus_grant,
  output logic [15:0] m_address,
  input  logic [15:0] m_data_in,
  output logic [15:0] m_data_out,
  output logic        m_r,
  output logic        m_w,
  output logic        done_irq
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    READ    = 3'd2,
    CAPTURE = 3'd3,
    WRITE   = 3'd4
  } state_t;

  state_t      state;
  logic [15:0] src, dst, len, buffer;
  logic        src_inc, dst_inc, done;
  logic        busy, wr_en, start_wr;
  logic [15:0] len_dec, src_next, dst_next;
  logic        unused_data_hi;

  assign busy     = (state != IDLE);
  assign wr_en    = cpu_cs & cpu_w;
  assign start_wr = wr_en && (cpu_addr == 2'd3) && cpu_data_in[0] && !busy;
  assign len_dec  = len - 16'd1;
  assign src_next = src_inc ? src + 16'd1 : src;
  assign dst_next = dst_inc ? dst + 16'd1 : dst;
  assign done_irq = done;

  // Only bits 4:0 of a CTRL write carry meaning
  assign unused_data_hi = ^cpu_data_in[15:5];

  // The captured word is only presented on the bus while WRITE is active
  assign m_data_out = (state == WRITE) ? buffer : 16'h0000;

  // Register read mux; SRC/DST/LEN show the live working values
  always_comb begin
    cpu_data_out = 16'h0000;
    if (cpu_cs && cpu_r) begin
      case (cpu_addr)
        2'd0:    cpu_data_out = src;
        2'd1:    cpu_data_out = dst;
        2'd2:    cpu_data_out = len;
        default: cpu_data_out = {11'h000, dst_inc, src_inc, done, busy, 1'b0};
      endcase
    end
  end

  // CPU register writes plus the transfer FSM with registered bus strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      src       <= 16'h0000;
      dst       <= 16'h0000;
      len       <= 16'h0000;
      buffer    <= 16'h0000;
      src_inc   <= 1'b0;
      dst_inc   <= 1'b0;
      done      <= 1'b0;
      bus_req   <= 1'b0;
      m_r       <= 1'b0;
      m_w       <= 1'b0;
      m_address <= 16'h0000;
    end else begin
      // Configuration is frozen while busy; the DONE clear always acts.
      // FSM assignments below come later so a same-edge DONE set wins.
      if (wr_en) begin
        case (cpu_addr)
          2'd0: if (!busy) src <= cpu_data_in;
          2'd1: if (!busy) dst <= cpu_data_in;
          2'd2: if (!busy) len <= cpu_data_in;
          default: begin
            if (cpu_data_in[2]) done <= 1'b0;
            if (!busy) begin
              src_inc <= cpu_data_in[3];
              dst_inc <= cpu_data_in[4];
            end
          end
        endcase
      end

      case (state)
        IDLE: begin
          if (start_wr) begin
            if (len == 16'h0000) begin
              done <= 1'b1;
            end else begin
              done    <= 1'b0;
              bus_req <= 1'b1;
              state   <= REQ;
            end
          end
        end
        REQ: begin
          if (bus_grant) begin
            m_r       <= 1'b1;
            m_address <= src;
            state     <= READ;
          end
        end
        READ: begin
          // Responder returns data during the following cycle
          m_r       <= 1'b0;
          m_address <= 16'h0000;
          state     <= CAPTURE;
        end
        CAPTURE: begin
          buffer    <= m_data_in;
          m_w       <= 1'b1;
          m_address <= dst;
          state     <= WRITE;
        end
        WRITE: begin
          m_w <= 1'b0;
          len <= len_dec;
          src <= src_next;
          dst <= dst_next;
          if (len_dec == 16'h0000) begin
            bus_req   <= 1'b0;
            done      <= 1'b1;
            m_address <= 16'h0000;
            state     <= IDLE;
          end else if (bus_grant) begin
            m_r       <= 1'b1;
            m_address <= src_next;
            state     <= READ;
          end else begin
            m_address <= 16'h0000;
            state     <= REQ;
          end
        end
        default: begin
          bus_req   <= 1'b0;
          m_r       <= 1'b0;
          m_w       <= 1'b0;
          m_address <= 16'h0000;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_controller.sv
// Bench for dma_controller: register-map vector table, a responder model
// and a scoreboard of expected bus strobes, plus directed transfer sequences.
module tb_dma_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_cs = 1'b0;
  logic [1:0]  cpu_addr = 2'd0;
  logic        cpu_w = 1'b0;
  logic        cpu_r = 1'b0;
  logic [15:0] cpu_data_in = 16'h0000;
  logic [15:0] cpu_data_out;
  logic        bus_req;
  logic        bus_grant = 1'b1;
  logic [15:0] m_address;
  logic [15:0] m_data_in = 16'h0000;
  logic [15:0] m_data_out;
  logic        m_r;
  logic        m_w;
  logic        done_irq;

  dma_controller dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_cs       (cpu_cs),
    .cpu_addr     (cpu_addr),
    .cpu_w        (cpu_w),
    .cpu_r        (cpu_r),
    .cpu_data_in  (cpu_data_in),
    .cpu_data_out (cpu_data_out),
    .bus_req      (bus_req),
    .bus_grant    (bus_grant),
    .m_address    (m_address),
    .m_data_in    (m_data_in),
    .m_data_out   (m_data_out),
    .m_r          (m_r),
    .m_w          (m_w),
    .done_irq     (done_irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
  } ev_t;

  typedef struct {
    logic [1:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;

  ev_t  exp_q[$];
  ev_t  ev;
  vec_t vecs[8];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   first_rd_cyc = 0;
  bit   first_rd_pending = 1'b0;
  bit   mon_en = 1'b0;
  bit   saw_req = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Responder: data is returned in the cycle after the read strobe
  always @(negedge clk) if (m_r) m_data_in = mem_word(m_address);

  // Bus monitor: every strobe must match the next expected event
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus_req) saw_req = 1'b1;
      if (m_r || m_w) begin
        chk("strobe_excl", {15'h0, m_r & m_w}, 16'h0000);
        if (first_rd_pending && m_r) begin
          first_rd_cyc     = cyc;
          first_rd_pending = 1'b0;
        end
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe r=%0d w=%0d addr=%h required=none", m_r, m_w, m_address);
        end else begin
          ev = exp_q.pop_front();
          chk("strobe_kind", {15'h0, m_w}, {15'h0, ev.wr});
          chk("strobe_addr", m_address, ev.addr);
          if (m_w) chk("write_data", m_data_out, ev.data);
          else     chk("read_dout_zero", m_data_out, 16'h0000);
        end
      end else begin
        chk("idle_addr", m_address, 16'h0000);
        chk("idle_dout", m_data_out, 16'h0000);
      end
    end
  end

  task automatic reg_write(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    cpu_cs = 1'b1; cpu_w = 1'b1; cpu_addr = a; cpu_data_in = d;
    @(negedge clk);
    cpu_cs = 1'b0; cpu_w = 1'b0;
  endtask

  task automatic reg_read(input logic [1:0] a, output logic [15:0] d);
    @(negedge clk);
    cpu_cs = 1'b1; cpu_r = 1'b1; cpu_addr = a;
    #1 d = cpu_data_out;
    cpu_cs = 1'b0; cpu_r = 1'b0;
  endtask

  task automatic push_xfer(input logic [15:0] s, input logic [15:0] d, input int n,
                           input bit sinc, input bit dinc);
    logic [15:0] sa, da;
    sa = s; da = d;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{wr: 1'b0, addr: sa, data: 16'h0000});
      exp_q.push_back('{wr: 1'b1, addr: da, data: mem_word(sa)});
      if (sinc) sa = sa + 16'd1;
      if (dinc) da = da + 16'd1;
    end
  endtask

  task automatic setup(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n);
    reg_write(2'd0, s);
    reg_write(2'd1, d);
    reg_write(2'd2, n);
  endtask

  task automatic wait_done(input string name, output int done_cyc);
    int k;
    done_cyc = 0;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done_irq) break;
    end
    if (k == 200) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=no_done required=done", name);
    end else begin
      done_cyc = cyc;
    end
  endtask

  task automatic wait_writes(input string name, input int n);
    int seen, k;
    seen = 0;
    for (k = 0; k < 100 && seen < n; k++) begin
      @(negedge clk);
      if (m_w) seen++;
    end
    if (seen < n) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=%0d required=%0d", name, seen, n);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd;
    int          dc;

    vecs[0] = '{2'd0, 16'h1234, 16'h1234};
    vecs[1] = '{2'd1, 16'hBEEF, 16'hBEEF};
    vecs[2] = '{2'd2, 16'h8001, 16'h8001};
    vecs[3] = '{2'd2, 16'h0000, 16'h0000};
    vecs[4] = '{2'd3, 16'hFFE6, 16'h0000};
    vecs[5] = '{2'd3, 16'h0018, 16'h0018};
    vecs[6] = '{2'd3, 16'hFFF8, 16'h0018};
    vecs[7] = '{2'd0, 16'hFFFF, 16'hFFFF};

    // Reset state: outputs and registers zero while reset is held
    repeat (3) @(negedge clk);
    chk("rst_bus_req", {15'h0, bus_req}, 16'h0000);
    chk("rst_m_r", {15'h0, m_r}, 16'h0000);
    chk("rst_m_w", {15'h0, m_w}, 16'h0000);
    chk("rst_irq", {15'h0, done_irq}, 16'h0000);
    chk("rst_addr", m_address, 16'h0000);
    chk("rst_dout", m_data_out, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      reg_read(2'(i), rd);
      chk("rst_reg", rd, 16'h0000);
    end
    reset = 1'b0;
    mon_en = 1'b1;

    // Register map table
    for (int i = 0; i < 8; i++) begin
      reg_write(vecs[i].addr, vecs[i].wdata);
      reg_read(vecs[i].addr, rd);
      chk($sformatf("regmap_%0d", i), rd, vecs[i].exp);
    end
    @(negedge clk);
    cpu_cs = 1'b0; cpu_r = 1'b1; cpu_addr = 2'd0;
    #1 chk("read_no_cs", cpu_data_out, 16'h0000);
    cpu_r = 1'b0;

    // Copy of 3 words with both increments
    setup(16'h0010, 16'h0400, 16'd3);
    push_xfer(16'h0010, 16'h0400, 3, 1'b1, 1'b1);
    first_rd_pending = 1'b1;
    reg_write(2'd3, 16'h0019);
    wait_done("copy", dc);
    chk("copy_cycles", 16'(dc - first_rd_cyc), 16'd9);
    reg_read(2'd3, rd);
    chk("copy_ctrl_status", rd & 16'h0007, 16'h0004);
    reg_read(2'd0, rd); chk("copy_src", rd, 16'h0013);
    reg_read(2'd1, rd); chk("copy_dst", rd, 16'h0403);
    reg_read(2'd2, rd); chk("copy_len", rd, 16'h0000);
    chk("copy_q_empty", 16'(exp_q.size()), 16'h0000);

    // Fill mode: one source word replicated to 4 destinations
    setup(16'h0200, 16'h0300, 16'd4);
    push_xfer(16'h0200, 16'h0300, 4, 1'b0, 1'b1);
    reg_write(2'd3, 16'h0011);
    wait_done("fill", dc);
    chk("fill_q_empty", 16'(exp_q.size()), 16'h0000);
    reg_read(2'd0, rd); chk("fill_src", rd, 16'h0200);

    // Zero length: immediate DONE, no bus request; DONE clear; clear loses to set
    reg_write(2'd3, 16'h0004);
    chk("done_clear", {15'h0, done_irq}, 16'h0000);
    reg_write(2'd2, 16'h0000);
    saw_req = 1'b0;
    reg_write(2'd3, 16'h0001);
    chk("zero_done", {15'h0, done_irq}, 16'h0001);
    repeat (3) @(negedge clk);
    chk("zero_no_req", {15'h0, saw_req}, 16'h0000);
    reg_write(2'd3, 16'h0004);
    chk("done_clear2", {15'h0, done_irq}, 16'h0000);
    reg_write(2'd3, 16'h0005);
    chk("clear_loses", {15'h0, done_irq}, 16'h0001);

    // Grant stall after START, with configuration writes ignored while busy
    bus_grant = 1'b0;
    setup(16'h0020, 16'h0500, 16'd2);
    push_xfer(16'h0020, 16'h0500, 2, 1'b1, 1'b1);
    reg_write(2'd3, 16'h0019);
    for (int i = 0; i < 5; i++) begin
      chk("stall_req", {15'h0, bus_req}, 16'h0001);
      chk("stall_no_strobe", {14'h0, m_r, m_w}, 16'h0000);
      @(negedge clk);
    end
    reg_write(2'd0, 16'hDEAD);
    reg_read(2'd0, rd); chk("busy_src_kept", rd, 16'h0020);
    reg_read(2'd3, rd); chk("busy_ctrl", rd, 16'h001A);
    bus_grant = 1'b1;
    wait_done("stall", dc);
    chk("stall_q_empty", 16'(exp_q.size()), 16'h0000);

    // Grant dropped at the end of word 1: re-arbitrate and resume
    setup(16'h0030, 16'h0600, 16'd3);
    push_xfer(16'h0030, 16'h0600, 3, 1'b1, 1'b1);
    reg_write(2'd3, 16'h0019);
    wait_writes("drop", 1);
    bus_grant = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("drop_req", {15'h0, bus_req}, 16'h0001);
      chk("drop_no_strobe", {14'h0, m_r, m_w}, 16'h0000);
    end
    bus_grant = 1'b1;
    wait_done("drop", dc);
    chk("drop_q_empty", 16'(exp_q.size()), 16'h0000);

    // Source address wraps from 0xFFFF to 0x0000
    setup(16'hFFFF, 16'h0700, 16'd2);
    push_xfer(16'hFFFF, 16'h0700, 2, 1'b1, 1'b1);
    reg_write(2'd3, 16'h0019);
    wait_done("wrap", dc);
    chk("wrap_q_empty", 16'(exp_q.size()), 16'h0000);
    reg_read(2'd0, rd); chk("wrap_src", rd, 16'h0001);

    // Reset during WRITE of word 2 of 4
    setup(16'h0800, 16'h0900, 16'd4);
    push_xfer(16'h0800, 16'h0900, 2, 1'b1, 1'b1);
    reg_write(2'd3, 16'h0019);
    wait_writes("abort", 2);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_req", {15'h0, bus_req}, 16'h0000);
    chk("abort_strobes", {14'h0, m_r, m_w}, 16'h0000);
    chk("abort_irq", {15'h0, done_irq}, 16'h0000);
    chk("abort_addr", m_address, 16'h0000);
    chk("abort_dout", m_data_out, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      reg_read(2'(i), rd);
      chk("abort_reg", rd, 16'h0000);
    end
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_q_empty", 16'(exp_q.size()), 16'h0000);
    chk("abort_idle_req", {15'h0, bus_req}, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
